bd_sync_receiver: RTL

- Synchronous receiving end of the two-phase bundled-data channel that the async pipeline drives.
- The async stage presents `inData` and toggles request `inR`; the request is routed through the matched delay elements so data settles before the request arrives.
- This block synchronizes `inR` into the `clk` domain, captures `inData` into a small FIFO, and returns a two-phase acknowledge `outA`.
- Captured words go to a clocked consumer over a valid/ready interface.

---
 rtl/bd_sync_receiver_if.sv | 29 ++
 rtl/bd_sync_receiver.sv | 82 ++++++++
 2 files changed

// File: rtl/bd_sync_receiver_if.sv
// Port bundle for bd_sync_receiver: the two-phase bundled-data side (inR/inData/outA)
// and the clocked valid/ready consumer side (o_valid/o_data/i_ready/o_count).
interface bd_sync_receiver_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  // Handshakes: each inR toggle offers one word on inData, which stays stable until
  // outA toggles to match inR; a word moves to the consumer on any clk edge where
  // o_valid && i_ready, and o_data holds the head word while o_valid is high.
  logic              inR;
  logic [DATA_W-1:0] inData;
  logic              outA;
  logic              o_valid;
  logic [DATA_W-1:0] o_data;
  logic              i_ready;
  logic [CW-1:0]     o_count;

  modport slave (
    input  inR, inData, i_ready,
    output outA, o_valid, o_data, o_count
  );

  modport master (
    output inR, inData, i_ready,
    input  outA, o_valid, o_data, o_count
  );
endinterface

// File: rtl/bd_sync_receiver.sv
// Clocked receiver for a two-phase bundled-data channel: synchronizes the request,
// captures the data word into a small first-word-fall-through FIFO and returns outA.
module bd_sync_receiver #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEPTH       = 2
) (
  input logic               clk,
  input logic               rst,
  bd_sync_receiver_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [SYNC_STAGES-1:0] syncFf;
  logic                   reqS;
  logic                   reqSeen;
  logic                   pending;
  logic                   full;
  logic                   notEmpty;
  logic                   capture;
  logic                   rdFire;
  logic [AW-1:0]          wrPtr;
  logic [AW-1:0]          rdPtr;
  logic [CW-1:0]          count;
  logic [DATA_W-1:0]      mem [DEPTH];

  // Plain flop chain: no logic may sit between synchronizer stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) syncFf <= '0;
    else     syncFf <= {syncFf[SYNC_STAGES-2:0], bus.inR};
  end

  assign reqS = syncFf[SYNC_STAGES-1];

  always_comb begin
    notEmpty = (count != '0);
    pending  = (reqS != reqSeen);
    full     = (count == CNT_FULL);
    capture  = pending && !full;
    rdFire   = notEmpty && bus.i_ready;
  end

  // reqSeen doubles as the acknowledge, so outA comes straight from this flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          reqSeen <= 1'b0;
    else if (capture) reqSeen <= reqS;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (capture) begin
      mem[wrPtr] <= bus.inData;
    end
  end

  // DEPTH is a power of two, so pointer wrap is the natural binary rollover.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (capture) wrPtr <= wrPtr + PTR_ONE;
      if (rdFire)  rdPtr <= rdPtr + PTR_ONE;
      case ({capture, rdFire})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  assign bus.outA    = reqSeen;
  assign bus.o_valid = notEmpty;
  assign bus.o_data  = mem[rdPtr];
  assign bus.o_count = count;
endmodule
